// File: rtl/fazyrv_seq_cntrl.sv
// Chunk-serial sequencing FSM: fetch, RF read latency, two execute parts, memory ack,
// shift, plus a trap pass for bus timeouts and interrupts taken at instruction boundaries.
module fazyrv_seq_cntrl #(
   parameter int CHUNKSIZE = 2,
   parameter int REG_WIDTH = 32,
   parameter int CPI       = REG_WIDTH / CHUNKSIZE,
   parameter int RF_RD_LAT = 1,
   parameter int MEMDLY1   = 0,
   parameter int TIMEOUT   = 255,
   parameter int TRAP_EN   = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   irq_i,
   input  logic                   pc_noinc_i,
   input  logic                   imem_ack_i,
   input  logic                   dmem_ack_i,
   input  logic                   any_jmp_i,
   input  logic                   any_br_i,
   input  logic                   any_ld_i,
   input  logic                   any_st_i,
   input  logic                   any_shft_i,
   input  logic                   any_slt_i,
   input  logic                   any_csr_i,
   input  logic                   shft_done_i,
   output logic                   imem_stb_o,
   output logic                   dmem_stb_o,
   output logic                   rf_ram_rstb_o,
   output logic                   rf_ram_wstb_o,
   output logic                   lsb_o,
   output logic                   msb_o,
   output logic                   pc_inc_o,
   output logic                   cyc_two_o,
   output logic                   cyc_ack_o,
   output logic                   cyc_shft_o,
   output logic                   cyc_trap_o,
   output logic                   hlt_regs_o,
   output logic                   hlt_spm_a_o,
   output logic                   hlt_imm_o,
   output logic [1:0]             trap_cause_o,
   output logic [$clog2(CPI)-1:0] icyc_o
);

   localparam int             CW       = $clog2(CPI);
   localparam logic [CW-1:0]  CYC_LAST = CW'(CPI - 1);
   localparam logic [1:0]     LAT_LAST = 2'((RF_RD_LAT > 0) ? RF_RD_LAT - 1 : 0);
   localparam logic [7:0]     TMO_MAX  = 8'(TIMEOUT);
   localparam bit             TMO_EN   = (TRAP_EN != 0) && (MEMDLY1 == 0) && (TIMEOUT != 0);

   typedef enum logic [2:0] {IFETCH, DECODE, ICYC1, ICYC2, ACK, SHIFT, TRAP} state_t;

   state_t        state;
   logic [CW-1:0] cyc;
   logic [1:0]    lat;
   logic [7:0]    tmo;
   logic          lsb_r;
   logic [1:0]    cause;

   logic imem_ack, dmem_ack, last_chunk, take_irq, two_part;

   assign imem_ack   = (MEMDLY1 != 0) || imem_ack_i;
   assign dmem_ack   = (MEMDLY1 != 0) || dmem_ack_i;
   assign last_chunk = (cyc == CYC_LAST);
   assign take_irq   = (TRAP_EN != 0) && irq_i;
   assign two_part   = any_jmp_i | any_br_i | any_st_i | any_slt_i | any_csr_i;

   // tmo only advances while the FSM sits in a strobing state, so any state change clears it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IFETCH;
         cyc   <= '0;
         lat   <= 2'd0;
         tmo   <= 8'd0;
         lsb_r <= 1'b0;
         cause <= 2'd0;
      end else begin
         lsb_r <= msb_o;
         tmo   <= 8'd0;
         case (state)
            IFETCH: begin
               cyc <= '0;
               lat <= 2'd0;
               if (imem_ack) begin
                  state <= (RF_RD_LAT == 0) ? ICYC1 : DECODE;
               end else if (TMO_EN && tmo == TMO_MAX) begin
                  state <= TRAP;
                  cause <= 2'd1;
               end else if (TMO_EN) begin
                  tmo <= tmo + 8'd1;
               end
            end
            DECODE: begin
               if (lat == LAT_LAST) begin
                  lat   <= 2'd0;
                  state <= ICYC1;
               end else begin
                  lat <= lat + 2'd1;
               end
            end
            ICYC1: begin
               cyc <= last_chunk ? '0 : cyc + 1'b1;
               if (last_chunk) begin
                  if (any_shft_i) begin
                     state <= shft_done_i ? ICYC2 : SHIFT;
                  end else if (any_ld_i) begin
                     state <= ACK;
                  end else if (two_part) begin
                     state <= ICYC2;
                  end else begin
                     state <= take_irq ? TRAP : IFETCH;
                     cause <= take_irq ? 2'd3 : 2'd0;
                  end
               end
            end
            ICYC2: begin
               cyc <= last_chunk ? '0 : cyc + 1'b1;
               if (last_chunk) begin
                  if (any_st_i) begin
                     state <= ACK;
                  end else begin
                     state <= take_irq ? TRAP : IFETCH;
                     cause <= take_irq ? 2'd3 : 2'd0;
                  end
               end
            end
            ACK: begin
               if (dmem_ack) begin
                  if (any_ld_i) begin
                     state <= shft_done_i ? ICYC2 : SHIFT;
                  end else begin
                     state <= take_irq ? TRAP : IFETCH;
                     cause <= take_irq ? 2'd3 : 2'd0;
                  end
               end else if (TMO_EN && tmo == TMO_MAX) begin
                  state <= TRAP;
                  cause <= 2'd2;
               end else if (TMO_EN) begin
                  tmo <= tmo + 8'd1;
               end
            end
            SHIFT: begin
               cyc <= '0;
               if (shft_done_i) state <= ICYC2;
            end
            TRAP: begin
               cyc <= last_chunk ? '0 : cyc + 1'b1;
               if (last_chunk) begin
                  state <= IFETCH;
                  cause <= 2'd0;
               end
            end
            default: state <= IFETCH;
         endcase
      end
   end

   // msb_o marks the chunk whose clock edge ends a part, so lsb_o follows it by one cycle
   always_comb begin
      imem_stb_o    = 1'b0;
      dmem_stb_o    = 1'b0;
      rf_ram_rstb_o = 1'b0;
      rf_ram_wstb_o = 1'b0;
      msb_o         = 1'b0;
      hlt_regs_o    = 1'b1;
      hlt_spm_a_o   = 1'b1;
      hlt_imm_o     = 1'b1;
      case (state)
         IFETCH: begin
            imem_stb_o    = 1'b1;
            rf_ram_wstb_o = 1'b1;
            msb_o         = 1'b1;
         end
         DECODE: begin
            rf_ram_rstb_o = 1'b1;
            msb_o         = 1'b1;
         end
         ICYC1: begin
            msb_o       = last_chunk;
            hlt_regs_o  = 1'b0;
            hlt_imm_o   = any_br_i;
            hlt_spm_a_o = any_shft_i & last_chunk;
         end
         ICYC2: begin
            msb_o      = last_chunk;
            hlt_regs_o = 1'b0;
            hlt_imm_o  = 1'b0;
         end
         ACK: begin
            dmem_stb_o = 1'b1;
            msb_o      = dmem_ack;
         end
         SHIFT: msb_o = shft_done_i;
         TRAP: begin
            msb_o         = last_chunk;
            hlt_regs_o    = 1'b0;
            rf_ram_wstb_o = last_chunk;
         end
         default: msb_o = 1'b0;
      endcase
      if (rst_i) begin
         imem_stb_o    = 1'b0;
         dmem_stb_o    = 1'b0;
         rf_ram_rstb_o = 1'b0;
         rf_ram_wstb_o = 1'b0;
         msb_o         = 1'b1;
         hlt_regs_o    = 1'b1;
         hlt_spm_a_o   = 1'b1;
         hlt_imm_o     = 1'b1;
      end
   end

   assign lsb_o        = lsb_r;
   assign pc_inc_o     = ~pc_noinc_i & lsb_r &
                         ((any_br_i | any_ld_i | any_st_i) ? (state == ICYC2) : (state == ICYC1));
   assign cyc_two_o    = (state == ICYC2);
   assign cyc_ack_o    = (state == ACK);
   assign cyc_shft_o   = (state == SHIFT);
   assign cyc_trap_o   = (state == TRAP);
   assign trap_cause_o = cause;
   assign icyc_o       = cyc;

endmodule

// File: tb/tb_fazyrv_seq_cntrl.sv
// Directed bench for fazyrv_seq_cntrl: three instances (RF_RD_LAT 1/0/3, TIMEOUT 4)
// share one stimulus; each scenario task checks the instance it targets.
module tb_fazyrv_seq_cntrl;

   logic clk;
   logic rst;
   logic irq, pc_noinc, imem_ack, dmem_ack;
   logic any_jmp, any_br, any_ld, any_st, any_shft, any_slt, any_csr, shft_done;

   logic       imem_stb [3];
   logic       dmem_stb [3];
   logic       rf_rstb  [3];
   logic       rf_wstb  [3];
   logic       lsb      [3];
   logic       msb      [3];
   logic       pc_inc   [3];
   logic       cyc_two  [3];
   logic       cyc_ack  [3];
   logic       cyc_shft [3];
   logic       cyc_trap [3];
   logic       hlt_regs [3];
   logic       hlt_spm_a[3];
   logic       hlt_imm  [3];
   logic [1:0] cause    [3];
   logic [3:0] icyc     [3];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fazyrv_seq_cntrl #(
         .RF_RD_LAT((g == 0) ? 1 : (g == 1) ? 0 : 3),
         .TIMEOUT  (4)
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .irq_i        (irq),
         .pc_noinc_i   (pc_noinc),
         .imem_ack_i   (imem_ack),
         .dmem_ack_i   (dmem_ack),
         .any_jmp_i    (any_jmp),
         .any_br_i     (any_br),
         .any_ld_i     (any_ld),
         .any_st_i     (any_st),
         .any_shft_i   (any_shft),
         .any_slt_i    (any_slt),
         .any_csr_i    (any_csr),
         .shft_done_i  (shft_done),
         .imem_stb_o   (imem_stb[g]),
         .dmem_stb_o   (dmem_stb[g]),
         .rf_ram_rstb_o(rf_rstb[g]),
         .rf_ram_wstb_o(rf_wstb[g]),
         .lsb_o        (lsb[g]),
         .msb_o        (msb[g]),
         .pc_inc_o     (pc_inc[g]),
         .cyc_two_o    (cyc_two[g]),
         .cyc_ack_o    (cyc_ack[g]),
         .cyc_shft_o   (cyc_shft[g]),
         .cyc_trap_o   (cyc_trap[g]),
         .hlt_regs_o   (hlt_regs[g]),
         .hlt_spm_a_o  (hlt_spm_a[g]),
         .hlt_imm_o    (hlt_imm[g]),
         .trap_cause_o (cause[g]),
         .icyc_o       (icyc[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed state letter decoded from the indicator outputs
   function automatic byte st(input int i);
      if (cyc_trap[i]) return "T";
      if (cyc_two[i])  return "2";
      if (cyc_ack[i])  return "A";
      if (cyc_shft[i]) return "S";
      if (imem_stb[i]) return "F";
      if (rf_rstb[i])  return "D";
      if (!hlt_regs[i]) return "1";
      return "?";
   endfunction

   task automatic clear_inputs();
      irq = 0; pc_noinc = 0; imem_ack = 0; dmem_ack = 0;
      any_jmp = 0; any_br = 0; any_ld = 0; any_st = 0;
      any_shft = 0; any_slt = 0; any_csr = 0; shft_done = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      clear_inputs();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1;
      clear_inputs();
      irq = 1; imem_ack = 1; dmem_ack = 1;
      #1;
      checks++;
      if ({imem_stb[0], dmem_stb[0], rf_rstb[0], rf_wstb[0]} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_strobes got %b expected 0000",
                  {imem_stb[0], dmem_stb[0], rf_rstb[0], rf_wstb[0]});
      end
      checks++;
      if ({hlt_regs[0], hlt_spm_a[0], hlt_imm[0], msb[0]} !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL reset_hlt_msb got %b expected 1111",
                  {hlt_regs[0], hlt_spm_a[0], hlt_imm[0], msb[0]});
      end
      checks++;
      if ({lsb[0], pc_inc[0], cyc_two[0], cyc_ack[0], cyc_shft[0], cyc_trap[0]} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b expected 000000",
                  {lsb[0], pc_inc[0], cyc_two[0], cyc_ack[0], cyc_shft[0], cyc_trap[0]});
      end
      checks++;
      if (cause[0] !== 2'd0 || icyc[0] !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_cause_icyc got %0d/%0d expected 0/0", cause[0], icyc[0]);
      end
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_stb[i] !== 1'b0 || rf_wstb[i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held_stb inst%0d got %b%b expected 00", i, imem_stb[i], rf_wstb[i]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_addi();
      int  pc_cnt = 0;
      byte exp_st;
      do_reset();
      for (int k = 0; k <= 18; k++) begin
         imem_ack = (k == 0);
         #1;
         exp_st = (k == 0 || k == 18) ? "F" : (k == 1) ? "D" : "1";
         checks++;
         if (st(0) !== exp_st) begin
            errors++;
            $display("[TB] FAIL addi_state k=%0d got %c expected %c", k, st(0), exp_st);
         end
         if (k >= 2 && k <= 17) begin
            checks++;
            if (icyc[0] !== 4'(k - 2) || msb[0] !== (k == 17) || hlt_spm_a[0] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL addi_chunk k=%0d got icyc=%0d msb=%b spm=%b expected icyc=%0d msb=%b spm=0",
                        k, icyc[0], msb[0], hlt_spm_a[0], k - 2, (k == 17));
            end
         end
         checks++;
         if (pc_inc[0] !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL addi_pc_inc k=%0d got %b expected %b", k, pc_inc[0], (k == 2));
         end
         if (pc_inc[0] === 1'b1) pc_cnt++;
         @(negedge clk);
      end
      checks++;
      if (pc_cnt != 1) begin
         errors++;
         $display("[TB] FAIL addi_pc_count got %0d expected 1", pc_cnt);
      end
   endtask

   task automatic test_branch();
      byte exp_st;
      do_reset();
      any_br = 1;
      for (int k = 0; k <= 34; k++) begin
         imem_ack = (k == 0);
         #1;
         exp_st = (k == 0 || k == 34) ? "F" : (k == 1) ? "D" : (k <= 17) ? "1" : "2";
         checks++;
         if (st(0) !== exp_st || pc_inc[0] !== (k == 18)) begin
            errors++;
            $display("[TB] FAIL br_state k=%0d got %c pc=%b expected %c pc=%b",
                     k, st(0), pc_inc[0], exp_st, (k == 18));
         end
         if (k >= 2 && k <= 33) begin
            checks++;
            if (hlt_imm[0] !== (k <= 17)) begin
               errors++;
               $display("[TB] FAIL br_hlt_imm k=%0d got %b expected %b", k, hlt_imm[0], (k <= 17));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_sw();
      int  stb_cnt = 0;
      byte exp_st;
      do_reset();
      any_st = 1;
      for (int k = 0; k <= 38; k++) begin
         imem_ack = (k == 0);
         dmem_ack = (k == 37);
         #1;
         exp_st = (k == 0 || k == 38) ? "F" : (k == 1) ? "D" : (k <= 17) ? "1" :
                  (k <= 33) ? "2" : "A";
         checks++;
         if (st(0) !== exp_st || pc_inc[0] !== (k == 18)) begin
            errors++;
            $display("[TB] FAIL sw_state k=%0d got %c pc=%b expected %c pc=%b",
                     k, st(0), pc_inc[0], exp_st, (k == 18));
         end
         if (dmem_stb[0] === 1'b1) stb_cnt++;
         @(negedge clk);
      end
      checks++;
      if (stb_cnt != 4) begin
         errors++;
         $display("[TB] FAIL sw_dmem_stb_len got %0d expected 4", stb_cnt);
      end
   endtask

   task automatic test_lw();
      byte exp_st;
      do_reset();
      any_ld = 1;
      for (int k = 0; k <= 40; k++) begin
         imem_ack  = (k == 0);
         dmem_ack  = (k == 18);
         shft_done = (k == 23);
         #1;
         exp_st = (k == 0 || k == 40) ? "F" : (k == 1) ? "D" : (k <= 17) ? "1" :
                  (k == 18) ? "A" : (k <= 23) ? "S" : "2";
         checks++;
         if (st(0) !== exp_st || pc_inc[0] !== (k == 24)) begin
            errors++;
            $display("[TB] FAIL lw_state k=%0d got %c pc=%b expected %c pc=%b",
                     k, st(0), pc_inc[0], exp_st, (k == 24));
         end
         if (k >= 18 && k <= 39) begin
            checks++;
            if (msb[0] !== (k == 18 || k == 23 || k == 39)) begin
               errors++;
               $display("[TB] FAIL lw_msb k=%0d got %b expected %b", k, msb[0],
                        (k == 18 || k == 23 || k == 39));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      int  stb_cnt = 0;
      byte exp_st;
      do_reset();
      for (int k = 0; k <= 21; k++) begin
         #1;
         exp_st = (k <= 4 || k == 21) ? "F" : "T";
         checks++;
         if (st(0) !== exp_st || cause[0] !== ((k >= 5 && k <= 20) ? 2'd1 : 2'd0)) begin
            errors++;
            $display("[TB] FAIL tmo_state k=%0d got %c cause=%0d expected %c cause=%0d",
                     k, st(0), cause[0], exp_st, (k >= 5 && k <= 20) ? 1 : 0);
         end
         if (k >= 5 && k <= 20) begin
            checks++;
            if (rf_wstb[0] !== (k == 20) || msb[0] !== (k == 20) || pc_inc[0] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL tmo_trap k=%0d got wstb=%b msb=%b pc=%b expected %b %b 0",
                        k, rf_wstb[0], msb[0], pc_inc[0], (k == 20), (k == 20));
            end
         end
         if (k <= 20 && imem_stb[0] === 1'b1) stb_cnt++;
         @(negedge clk);
      end
      checks++;
      if (stb_cnt != 5) begin
         errors++;
         $display("[TB] FAIL tmo_stb_len got %0d expected 5", stb_cnt);
      end
   endtask

   task automatic test_timeout_ack_wins();
      byte exp_st;
      do_reset();
      for (int k = 0; k <= 6; k++) begin
         imem_ack = (k == 4);
         #1;
         exp_st = (k <= 4) ? "F" : (k == 5) ? "D" : "1";
         checks++;
         if (st(0) !== exp_st) begin
            errors++;
            $display("[TB] FAIL ack_wins k=%0d got %c expected %c", k, st(0), exp_st);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_irq();
      byte exp_st;
      do_reset();
      for (int k = 0; k <= 34; k++) begin
         imem_ack = (k == 0);
         irq      = (k >= 5 && k <= 18);
         #1;
         exp_st = (k == 0 || k == 34) ? "F" : (k == 1) ? "D" : (k <= 17) ? "1" : "T";
         checks++;
         if (st(0) !== exp_st || cause[0] !== ((exp_st == "T") ? 2'd3 : 2'd0)) begin
            errors++;
            $display("[TB] FAIL irq_state k=%0d got %c cause=%0d expected %c cause=%0d",
                     k, st(0), cause[0], exp_st, (exp_st == "T") ? 3 : 0);
         end
         checks++;
         if (pc_inc[0] !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL irq_pc_inc k=%0d got %b expected %b", k, pc_inc[0], (k == 2));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rst_mid_ack();
      int lat_exp [3] = '{1, 0, 3};
      int rd_cnt  [3] = '{0, 0, 0};
      do_reset();
      any_st = 1;
      for (int k = 0; k < 36; k++) begin
         imem_ack = (k == 0);
         @(negedge clk);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cyc_ack[i] !== 1'b1 || dmem_stb[i] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pre_ack inst%0d got ack=%b stb=%b expected 1 1", i, cyc_ack[i], dmem_stb[i]);
         end
      end
      rst = 1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({imem_stb[i], dmem_stb[i], rf_rstb[i], rf_wstb[i], cyc_ack[i], msb[i]} !== 6'b000001) begin
            errors++;
            $display("[TB] FAIL rst_async inst%0d got %b expected 000001", i,
                     {imem_stb[i], dmem_stb[i], rf_rstb[i], rf_wstb[i], cyc_ack[i], msb[i]});
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (dmem_stb[0] !== 1'b0 || imem_stb[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_held got dmem=%b imem=%b expected 0 0", dmem_stb[0], imem_stb[0]);
      end
      @(negedge clk);
      rst    = 0;
      any_st = 0;
      for (int j = 0; j <= 6; j++) begin
         imem_ack = (j == 0);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (rf_rstb[i] === 1'b1) rd_cnt[i]++;
            if (j == 0 || j == lat_exp[i] + 1) begin
               checks++;
               if (st(i) !== ((j == 0) ? "F" : "1")) begin
                  errors++;
                  $display("[TB] FAIL restart inst%0d j=%0d got %c expected %c", i, j, st(i),
                           (j == 0) ? "F" : "1");
               end
            end
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rd_cnt[i] != lat_exp[i]) begin
            errors++;
            $display("[TB] FAIL decode_len inst%0d got %0d expected %0d", i, rd_cnt[i], lat_exp[i]);
         end
      end
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_addi();
      test_branch();
      test_sw();
      test_lw();
      test_timeout();
      test_timeout_ack_wins();
      test_irq();
      test_rst_mid_ack();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
